// File: rtl/bin_loader.sv
// Purpose : loads a PAL BIN paper-tape image (8-bit frames) into 12-bit memory and verifies the trailing checksum.
// Latency : a data word is written once the following word's high frame is accepted; done rises the cycle after the trailer is accepted.
// Backpr. : in_ready drops for the whole memory write (until mem_finished) and permanently once done.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data/in_valid/in_ready  tape frame stream, frame taken when in_valid && in_ready
//   address/write_data/write_enable/mem_finished
//                              memory write port, write_enable held until the mem_finished pulse
//   busy, done, checksum_ok, checksum_err
//                              load status, done and the checksum flags are sticky until reset
module bin_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] address,
    output logic [11:0] write_data,
    output logic        write_enable,
    input  logic        mem_finished,
    output logic        busy,
    output logic        done,
    output logic        checksum_ok,
    output logic        checksum_err
);

    typedef enum logic [2:0] {
        LEADER,
        HIGH,
        LOW_DONE,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  cur_hi;      // high frame of the word being assembled
    logic [7:0]  pend_hi;     // frames of the assembled, not yet committed word
    logic [7:0]  pend_lo;
    logic [11:0] sum;
    logic [11:0] load_addr;

    logic        accept;
    logic        is_trailer;  // 0o200-class frame: leader or trailer
    logic        is_field;    // field-setting frame, ignored everywhere
    logic        is_high;     // origin or data high frame
    logic [11:0] pend_word;
    logic        pend_origin;

    assign accept      = in_valid && in_ready;
    assign is_trailer  = (in_data[7:6] == 2'b10);
    assign is_field    = (in_data[7:6] == 2'b11);
    assign is_high     = !in_data[7];
    assign pend_word   = {pend_hi[5:0], pend_lo[5:0]};
    assign pend_origin = pend_hi[6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LEADER;
            cur_hi       <= 8'd0;
            pend_hi      <= 8'd0;
            pend_lo      <= 8'd0;
            sum          <= 12'd0;
            load_addr    <= 12'd0;
            in_ready     <= 1'b1;
            address      <= 12'd0;
            write_data   <= 12'd0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            checksum_ok  <= 1'b0;
            checksum_err <= 1'b0;
        end else begin
            case (state)
                LEADER: begin
                    // Leader frames (and stray 0o200 with nothing pending) are skipped.
                    if (accept && is_high) begin
                        cur_hi <= in_data;
                        busy   <= 1'b1;
                        state  <= HIGH;
                    end
                end

                HIGH: begin
                    if (accept) begin
                        if (is_trailer) begin
                            // Tape ended mid-word: format error.
                            done         <= 1'b1;
                            checksum_err <= 1'b1;
                            busy         <= 1'b0;
                            in_ready     <= 1'b0;
                            state        <= DONE;
                        end else if (!is_field) begin
                            pend_hi <= cur_hi;
                            pend_lo <= in_data;
                            state   <= LOW_DONE;
                        end
                    end
                end

                LOW_DONE: begin
                    if (accept) begin
                        if (is_trailer) begin
                            // The pending word is the checksum; it is never written.
                            done         <= 1'b1;
                            checksum_ok  <= (pend_word == sum);
                            checksum_err <= (pend_word != sum);
                            busy         <= 1'b0;
                            in_ready     <= 1'b0;
                            state        <= DONE;
                        end else if (is_high) begin
                            // A new word starts, so the pending one is real data: commit it.
                            sum    <= sum + {4'd0, pend_hi} + {4'd0, pend_lo};
                            cur_hi <= in_data;
                            if (pend_origin) begin
                                load_addr <= pend_word;
                                state     <= HIGH;
                            end else begin
                                address      <= load_addr;
                                write_data   <= pend_word;
                                write_enable <= 1'b1;
                                in_ready     <= 1'b0;
                                state        <= WRITE;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (mem_finished) begin
                        write_enable <= 1'b0;
                        in_ready     <= 1'b1;
                        load_addr    <= load_addr + 12'd1;
                        state        <= HIGH;
                    end
                end

                DONE: begin
                    // Sticky until reset.
                end

                default: state <= LEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_loader.sv
module tb_bin_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] address;
    logic [11:0] write_data;
    logic        write_enable;
    logic        mem_finished;
    logic        busy;
    logic        done;
    logic        checksum_ok;
    logic        checksum_err;

    logic        resp_fin;
    logic        stale_fin;
    assign mem_finished = resp_fin | stale_fin;

    always #5 clk = ~clk;

    bin_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .mem_finished (mem_finished),
        .busy         (busy),
        .done         (done),
        .checksum_ok  (checksum_ok),
        .checksum_err (checksum_err)
    );

    int          errors = 0;
    int          checks = 0;
    int          mem_delay = 1;
    bit          mem_hold = 1'b0;
    bit          watch_ready = 1'b0;
    logic [23:0] exp_q[$];        // expected writes {address, data}
    logic [7:0]  stream[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // Memory model: answers each write after mem_delay cycles and checks it against the scoreboard.
    initial begin
        int cnt;
        logic [23:0] e;
        cnt = 0;
        resp_fin = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_fin = 1'b0;
            if (write_enable) begin
                if (watch_ready) chk("in_ready_low_during_write", in_ready, 0);
                if (!mem_hold) begin
                    cnt++;
                    if (cnt >= mem_delay) begin
                        chk("write_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("write_address", address, e[23:12]);
                            chk("write_data", write_data, e[11:0]);
                        end
                        resp_fin = 1'b1;
                        cnt = 0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic send(input logic [7:0] f);
        int t;
        t = 0;
        in_data  = f;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frame_accept_in_time", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream();
        foreach (stream[i]) send(stream[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_write_enable"}, write_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ok"}, checksum_ok, 0);
        chk({tag, "_err"}, checksum_err, 0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_write_data"}, write_data, 0);
    endtask

    task automatic chk_end(input string tag, input logic ok, input logic err);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ok"}, checksum_ok, ok);
        chk({tag, "_err"}, checksum_err, err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_all_writes_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        stale_fin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_outputs("reset");

        // Basic load: origin 0200, data 7200, checksum 0174.
        exp_q.push_back({12'o0200, 12'o7200});
        send(8'o200);
        send(8'o200);
        chk("leader_not_busy", busy, 0);
        send(8'o102);
        chk("busy_after_first_frame", busy, 1);
        stream = '{8'o000, 8'o072, 8'o000, 8'o001, 8'o074, 8'o200};
        send_stream();
        chk_end("basic", 1'b1, 1'b0);
        // DONE is sticky and refuses frames.
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("done_sticky", done, 1);
        chk("done_no_accept", in_ready, 0);

        // Checksum mismatch.
        do_reset();
        exp_q.push_back({12'o0200, 12'o7200});
        stream = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o072, 8'o000, 8'o001, 8'o075, 8'o200};
        send_stream();
        chk_end("mismatch", 1'b0, 1'b1);

        // Address wrap 7777 -> 0000; sum = 0o177+0o077+1+2 = 0o301. Field frame is ignored.
        do_reset();
        exp_q.push_back({12'o7777, 12'o0001});
        exp_q.push_back({12'o0000, 12'o0002});
        stream = '{8'o200, 8'o177, 8'o077, 8'o300, 8'o000, 8'o001, 8'o000, 8'o002,
                   8'o003, 8'o001, 8'o200};
        send_stream();
        chk_end("wrap", 1'b1, 1'b0);

        // Backpressure: slow memory, in_valid held high across frames.
        do_reset();
        mem_delay   = 7;
        watch_ready = 1'b1;
        exp_q.push_back({12'o0200, 12'o7200});
        stream = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o072, 8'o000, 8'o001, 8'o074, 8'o200};
        send_stream();
        chk_end("backpressure", 1'b1, 1'b0);
        watch_ready = 1'b0;
        mem_delay   = 1;

        // Truncated word.
        do_reset();
        stream = '{8'o200, 8'o102, 8'o200};
        send_stream();
        chk_end("truncated", 1'b0, 1'b1);

        // Reset while a write is outstanding.
        do_reset();
        mem_hold = 1'b1;
        stream = '{8'o200, 8'o102, 8'o000, 8'o072, 8'o000, 8'o001};
        send_stream();
        chk("midwrite_we_high", write_enable, 1);
        chk("midwrite_ready_low", in_ready, 0);
        do_reset();
        chk_reset_outputs("after_reset");
        stale_fin = 1'b1;
        @(posedge clk);
        #1;
        stale_fin = 1'b0;
        mem_hold  = 1'b0;
        chk_reset_outputs("stale_fin");
        exp_q.push_back({12'o0200, 12'o7200});
        stream = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o072, 8'o000, 8'o001, 8'o074, 8'o200};
        send_stream();
        chk_end("reload", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
